spi_slave_regfile: RTL and testbench
====================================

SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, data frame width (8..32).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 2, register index width (1..7); register count 2**ADDR_WIDTH.
REQ-003 The block SHALL have parameter SPI_MODE, default 0, {CPOL,CPHA} encoding 0..3.
REQ-004 clk  input  1  system clock; one clock, all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 SCLK  input  1  SPI clock from master, asynchronous to clk.
REQ-007 SS  input  1  slave select, active-low, asynchronous.
REQ-008 MOSI  input  1  master-out serial data, asynchronous.
REQ-009 MISO  output  1  slave-out serial data; 1'bz when miso_oe low.
REQ-010 miso_oe  output  1  high while synchronized SS low.
REQ-011 host_raddr  input  ADDR_WIDTH  host-side register read index.
REQ-012 host_rdata  output  DATA_WIDTH  combinational read of register host_raddr.
REQ-013 wr_strobe  output  1  one-clk pulse per completed SPI write frame.
REQ-014 wr_addr / wr_data  output  ADDR_WIDTH / DATA_WIDTH  index and value of that write, held until next strobe.
REQ-015 done  output  1  one-clk pulse when SS deasserts after at least one complete frame.

Function
REQ-016 SCLK, SS, MOSI SHALL pass through 2-flop synchronizers; SCLK edges SHALL be detected on synchronized value; clk SHALL be >= 8x SCLK.
REQ-017 Sample edge = leading edge if CPHA=0, trailing if CPHA=1; launch edge = opposite; leading edge = rising if CPOL=0, falling if CPOL=1.
REQ-018 Transfer: 8-bit command frame MSB first, bit7 = 1 write / 0 read, bits[ADDR_WIDTH-1:0] = start index, other bits ignored; then DATA_WIDTH-bit data frames MSB first.
REQ-019 FSM states IDLE, CMD, WR_DATA, RD_DATA; IDLE->CMD on SS fall; CMD->WR_DATA or RD_DATA after 8th sample edge per bit7; any state->IDLE on SS rise.
REQ-020 WR_DATA: after DATA_WIDTH-th sample edge, register[index] SHALL update, wr_strobe pulse one clk later, index advance per REQ-030.
REQ-021 RD_DATA: register[index] SHALL be loaded into MISO shifter at end of CMD (CPHA=0: on 8th launch edge; CPHA=1: on 8th sample edge, next launch edge not shifting); MSB valid before first data sample edge.
REQ-022 Each subsequent read frame SHALL reload from the advanced index on the same rule; MISO = 0 during CMD.
REQ-023 Partial frames (SS rise mid-frame) SHALL be discarded: no register update, no wr_strobe; done pulses only if >=1 full data frame completed.
REQ-024 Index SHALL wrap from 2**ADDR_WIDTH-1 to 0.
REQ-025 Simultaneous host_raddr read and SPI write to the same index SHALL return the old value until the update clk, new value thereafter.
REQ-026 Edges seen while SS synchronized high SHALL be ignored.

Reset
REQ-027 On rst low: all registers 0, FSM IDLE, shifters 0, bit counter 0, wr_strobe 0, done 0, wr_addr 0, wr_data 0, miso_oe 0.
REQ-028 Reset mid-transfer SHALL abort it immediately; after rst release the block SHALL wait for a fresh SS fall.

Configuration
REQ-029 Macro SPI_SLAVE_AUTOINC_EN SHALL select burst addressing.
REQ-030 Defined: index increments after every data frame (wrap per REQ-024); undefined: only first data frame acts, further write frames ignored, further read frames shift out 0.

Verification
REQ-031 Mode 0, SS low, MOSI 0x82 then 0xA5, SS high -> reg2=0xA5, wr_strobe once with wr_addr=2, wr_data=0xA5, done pulse.
REQ-032 reg1=0x3C, mode 3, MOSI 0x01 then 16 clocks -> MISO 0x3C, registers unchanged, no wr_strobe.
REQ-033 AUTOINC_EN, MOSI 0x83,0x11,0x22 -> reg3=0x11, reg0=0x22 (wrap); undefined -> reg3=0x11, reg0 unchanged.
REQ-034 MOSI 0x80 then 4 data bits, SS high -> reg0 unchanged, no wr_strobe, no done.
REQ-035 rst low after 5 data bits of write to reg1 -> all outputs reset values; next full 0x81,0x77 -> reg1=0x77.
REQ-036 SPI_MODE 1 and 2, DATA_WIDTH 16: write 0x80,0xBEEF then read 0x00 -> MISO 0xBEEF, host_rdata(0)=0xBEEF.

Source files
------------

// File: rtl/spi_slave_regfile.sv
// SPI slave exposing a small register file to an SPI master.
// An 8-bit command frame (bit7 = write, low bits = start index) is followed by data frames.
// The host side reads registers combinationally and sees a strobe per completed SPI write.
// Build option: define SPI_SLAVE_AUTOINC_EN for burst addressing, where the index advances
// after every data frame. Otherwise only the first data frame of a transfer takes effect.
module spi_slave_regfile #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned SPI_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCLK,
    input  logic                  SS,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  miso_oe,
    input  logic [ADDR_WIDTH-1:0] host_raddr,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  wr_strobe,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  done
);

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;
    localparam int unsigned CntW    = 6;
    localparam bit Cpol = ((SPI_MODE >> 1) & 1) != 0;
    localparam bit Cpha = (SPI_MODE & 1) != 0;
`ifdef SPI_SLAVE_AUTOINC_EN
    localparam bit AutoInc = 1'b1;
`else
    localparam bit AutoInc = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StCmd, StWrData, StRdData} state_e;

    logic [2:0]            sclk_q;
    logic [1:0]            ss_q;
    logic [1:0]            mosi_q;
    logic                  armed_q;
    state_e                state_q;
    logic [CntW-1:0]       bit_cnt_q;
    logic [DATA_WIDTH-2:0] rx_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  load_q;
    logic                  skip_q;
    logic                  seen_q;
    logic                  wr_pend_q;
    logic                  wr_strobe_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] regs_q [NumRegs];

    logic                  ss_low;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  sample_e;
    logic                  launch_e;
    logic [DATA_WIDTH-1:0] data_word;
    logic [ADDR_WIDTH-1:0] cmd_idx;
    logic [ADDR_WIDTH-1:0] next_idx;
    logic                  frame_end;
    logic                  act;

    // Two-flop synchronizers; armed_q blocks a transfer until SS has been seen high after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_q  <= {3{Cpol}};
            ss_q    <= 2'b00;
            mosi_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sclk_q  <= {sclk_q[1:0], SCLK};
            ss_q    <= {ss_q[0], SS};
            mosi_q  <= {mosi_q[0], MOSI};
            armed_q <= armed_q | ss_q[1];
        end
    end

    assign ss_low    = armed_q & ~ss_q[1];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    // Leading edge leaves the idle level; CPHA picks which edge samples
    assign sample_e  = ss_low & (Cpha ? (Cpol ? sclk_rise : sclk_fall)
                                      : (Cpol ? sclk_fall : sclk_rise));
    assign launch_e  = ss_low & (Cpha ? (Cpol ? sclk_fall : sclk_rise)
                                      : (Cpol ? sclk_rise : sclk_fall));
    assign data_word = {rx_q, mosi_q[1]};
    assign cmd_idx   = data_word[ADDR_WIDTH-1:0];
    assign next_idx  = AutoInc ? idx_q + ADDR_WIDTH'(1) : idx_q;
    assign frame_end = (bit_cnt_q == CntW'(DATA_WIDTH - 1));
    // Without auto-increment only the first data frame of a transfer does anything
    assign act       = AutoInc | ~seen_q;

    // Transfer FSM with shifters, register file and host-side strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            idx_q       <= '0;
            load_q      <= 1'b0;
            skip_q      <= 1'b0;
            seen_q      <= 1'b0;
            wr_pend_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            regs_q      <= '{default: '0};
        end else begin
            wr_strobe_q <= wr_pend_q;
            wr_pend_q   <= 1'b0;
            done_q      <= 1'b0;
            if (state_q != StIdle && !ss_low) begin
                // SS released: drop any partial frame
                state_q   <= StIdle;
                done_q    <= seen_q;
                bit_cnt_q <= '0;
                load_q    <= 1'b0;
                skip_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (ss_low) begin
                            state_q   <= StCmd;
                            bit_cnt_q <= '0;
                            rx_q      <= '0;
                            tx_q      <= '0;
                            seen_q    <= 1'b0;
                            load_q    <= 1'b0;
                            skip_q    <= 1'b0;
                        end
                    end
                    StCmd: begin
                        if (sample_e) begin
                            rx_q <= data_word[DATA_WIDTH-2:0];
                            if (bit_cnt_q == CntW'(7)) begin
                                bit_cnt_q <= '0;
                                idx_q     <= cmd_idx;
                                if (rx_q[6]) begin
                                    state_q <= StWrData;
                                end else begin
                                    state_q <= StRdData;
                                    if (Cpha) begin
                                        tx_q   <= regs_q[cmd_idx];
                                        skip_q <= 1'b1;
                                    end else begin
                                        load_q <= 1'b1;
                                    end
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    StWrData: begin
                        if (sample_e) begin
                            rx_q <= data_word[DATA_WIDTH-2:0];
                            if (frame_end) begin
                                bit_cnt_q <= '0;
                                seen_q    <= 1'b1;
                                idx_q     <= next_idx;
                                if (act) begin
                                    regs_q[idx_q] <= data_word;
                                    wr_addr_q     <= idx_q;
                                    wr_data_q     <= data_word;
                                    wr_pend_q     <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    StRdData: begin
                        if (launch_e) begin
                            if (load_q) begin
                                tx_q   <= act ? regs_q[idx_q] : '0;
                                load_q <= 1'b0;
                            end else if (skip_q) begin
                                skip_q <= 1'b0;
                            end else begin
                                tx_q <= tx_q << 1;
                            end
                        end
                        if (sample_e) begin
                            rx_q <= data_word[DATA_WIDTH-2:0];
                            if (frame_end) begin
                                bit_cnt_q <= '0;
                                seen_q    <= 1'b1;
                                idx_q     <= next_idx;
                                if (Cpha) begin
                                    tx_q   <= AutoInc ? regs_q[next_idx] : '0;
                                    skip_q <= 1'b1;
                                end else begin
                                    load_q <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign miso_oe    = ss_low;
    assign MISO       = ss_low ? tx_q[DATA_WIDTH-1] : 1'bz;
    assign host_rdata = regs_q[host_raddr];
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign done       = done_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: dev0 is mode 0 / 8-bit, dev1 is mode 3 / 16-bit.
// Expected register contents and MISO frames come from a transfer-level model.
module tb_spi_slave_regfile;

    localparam int DW0 = 8;
    localparam int DW1 = 16;
`ifdef SPI_SLAVE_AUTOINC_EN
    localparam bit AutoInc = 1'b1;
`else
    localparam bit AutoInc = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [1:0]     sclk = 2'b10;
    logic [1:0]     ss = 2'b11;
    logic [1:0]     mosi = 2'b00;
    wire            miso0, miso1;
    logic           oe0, oe1, stb0, stb1, done0, done1;
    logic [1:0]     raddr0 = '0, raddr1 = '0, waddr0, waddr1;
    logic [DW0-1:0] rdata0, wdata0;
    logic [DW1-1:0] rdata1, wdata1;

    int             checks = 0;
    int             errors = 0;
    int             stb_cnt [2] = '{0, 0};
    int             done_cnt [2] = '{0, 0};
    logic [1:0]     last_wa [2];
    logic [31:0]    last_wd [2];
    logic [31:0]    mreg [2][4];
    logic [31:0]    dq [$];

    always #5 clk = ~clk;

    spi_slave_regfile #(.DATA_WIDTH(DW0), .ADDR_WIDTH(2), .SPI_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .SCLK(sclk[0]), .SS(ss[0]), .MOSI(mosi[0]), .MISO(miso0),
        .miso_oe(oe0), .host_raddr(raddr0), .host_rdata(rdata0), .wr_strobe(stb0),
        .wr_addr(waddr0), .wr_data(wdata0), .done(done0)
    );

    spi_slave_regfile #(.DATA_WIDTH(DW1), .ADDR_WIDTH(2), .SPI_MODE(3)) u_dut1 (
        .clk(clk), .rst(rst), .SCLK(sclk[1]), .SS(ss[1]), .MOSI(mosi[1]), .MISO(miso1),
        .miso_oe(oe1), .host_raddr(raddr1), .host_rdata(rdata1), .wr_strobe(stb1),
        .wr_addr(waddr1), .wr_data(wdata1), .done(done1)
    );

    // Pulse monitors, sampled on the falling clock edge
    always @(negedge clk) begin
        if (stb0) begin stb_cnt[0]++; last_wa[0] = waddr0; last_wd[0] = 32'(wdata0); end
        if (stb1) begin stb_cnt[1]++; last_wa[1] = waddr1; last_wd[1] = 32'(wdata1); end
        if (done0) done_cnt[0]++;
        if (done1) done_cnt[1]++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic miso_of(input int dev);
        return (dev == 1) ? miso1 : miso0;
    endfunction

    function automatic logic [31:0] rdata_of(input int dev);
        return (dev == 1) ? 32'(rdata1) : 32'(rdata0);
    endfunction

    // Master: dev0 mode 0, dev1 mode 3; MISO captured at each sample edge
    task automatic drive_bits(input int dev, input bit b[$], output bit r[$]);
        bit cpol;
        cpol = (dev == 1);
        r = {};
        foreach (b[i]) begin
            if (dev == 0) begin
                mosi[dev] = b[i]; #80;
                sclk[dev] = ~cpol; r.push_back(miso_of(dev)); #80;
                sclk[dev] = cpol;
            end else begin
                sclk[dev] = ~cpol; mosi[dev] = b[i]; #80;
                sclk[dev] = cpol; r.push_back(miso_of(dev)); #80;
            end
        end
    endtask

    task automatic check_regs(input int dev);
        for (int i = 0; i < 4; i++) begin
            if (dev == 1) raddr1 = 2'(i); else raddr0 = 2'(i);
            #1;
            chk($sformatf("dev%0d_reg%0d", dev, i), rdata_of(dev), mreg[dev][i]);
            #9;
        end
    endtask

    task automatic check_reset_outs(input int dev);
        chk($sformatf("dev%0d_rst_oe", dev), 32'((dev == 1) ? oe1 : oe0), 0);
        chk($sformatf("dev%0d_rst_stb", dev), 32'((dev == 1) ? stb1 : stb0), 0);
        chk($sformatf("dev%0d_rst_done", dev), 32'((dev == 1) ? done1 : done0), 0);
        chk($sformatf("dev%0d_rst_waddr", dev), 32'((dev == 1) ? waddr1 : waddr0), 0);
        chk($sformatf("dev%0d_rst_wdata", dev), (dev == 1) ? 32'(wdata1) : 32'(wdata0), 0);
    endtask

    // One transfer: command, nfr full data frames from dq, then 'extra' bits of dq[nfr]
    task automatic xfer(input int dev, input logic [7:0] cmd, input int nfr, input int extra);
        int          dw, s0, d0, exp_stb, idx;
        bit          act;
        bit          b[$];
        bit          r[$];
        logic [31:0] mask, got, exp_wa, exp_wd;
        dw   = (dev == 1) ? DW1 : DW0;
        mask = (32'd1 << dw) - 32'd1;
        for (int i = 7; i >= 0; i--) b.push_back(cmd[i]);
        for (int k = 0; k < nfr; k++)
            for (int i = dw - 1; i >= 0; i--) b.push_back(dq[k][i]);
        for (int i = 0; i < extra; i++) b.push_back(dq[nfr][dw-1-i]);
        s0 = stb_cnt[dev];
        d0 = done_cnt[dev];
        ss[dev] = 1'b0; #100;
        drive_bits(dev, b, r);
        #80; ss[dev] = 1'b1; #200;

        got = 0;
        for (int i = 0; i < 8; i++) got = {got[30:0], r[i]};
        chk($sformatf("dev%0d_cmd%02h_miso_cmd", dev, cmd), got, 0);
        exp_stb = 0; exp_wa = 0; exp_wd = 0;
        for (int k = 0; k < nfr; k++) begin
            act = AutoInc || (k == 0);
            idx = AutoInc ? (int'(cmd[1:0]) + k) % 4 : int'(cmd[1:0]);
            if (cmd[7]) begin
                if (act) begin
                    mreg[dev][idx] = dq[k] & mask;
                    exp_stb++;
                    exp_wa = 32'(idx);
                    exp_wd = dq[k] & mask;
                end
            end else begin
                got = 0;
                for (int i = 0; i < dw; i++) got = {got[30:0], r[8 + k*dw + i]};
                chk($sformatf("dev%0d_cmd%02h_rd%0d", dev, cmd, k), got,
                    act ? mreg[dev][idx] : 32'd0);
            end
        end
        chk($sformatf("dev%0d_cmd%02h_strobes", dev, cmd), 32'(stb_cnt[dev] - s0), 32'(exp_stb));
        if (exp_stb > 0) begin
            chk($sformatf("dev%0d_cmd%02h_waddr", dev, cmd), 32'(last_wa[dev]), exp_wa);
            chk($sformatf("dev%0d_cmd%02h_wdata", dev, cmd), last_wd[dev], exp_wd);
        end
        chk($sformatf("dev%0d_cmd%02h_done", dev, cmd), 32'(done_cnt[dev] - d0),
            (nfr > 0) ? 32'd1 : 32'd0);
        check_regs(dev);
    endtask

    initial begin
        int          dev, nfr, extra;
        logic [7:0]  cmd;
        bit          b[$];
        bit          r[$];
        logic [31:0] tmp;
        int          s0;

        for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) mreg[d][i] = 0;
        #30;
        check_reset_outs(0);
        check_reset_outs(1);
        check_regs(0);
        rst = 1'b1;
        #100;

        // Single write, mode 0
        dq = {32'hA5};
        xfer(0, 8'h82, 1, 0);
        // Write then read back reg1 in mode 3
        dq = {32'h003C};
        xfer(1, 8'h81, 1, 0);
        dq = {};
        xfer(1, 8'h01, 1, 0);
        // Burst write starting at the top index
        dq = {32'h11, 32'h22};
        xfer(0, 8'h83, 2, 0);
        // Partial data frame is dropped
        dq = {32'hFF};
        xfer(0, 8'h80, 0, 4);
        // 16-bit write then read of reg0
        dq = {32'hBEEF};
        xfer(1, 8'h80, 1, 0);
        dq = {};
        xfer(1, 8'h00, 1, 0);
        // Read burst over three frames
        xfer(0, 8'h02, 3, 0);

        // Clocks with SS high are ignored
        s0 = stb_cnt[0];
        b = {};
        tmp = 32'h82FF;
        for (int i = 15; i >= 0; i--) b.push_back(tmp[i]);
        drive_bits(0, b, r);
        #100;
        chk("ss_high_strobes", 32'(stb_cnt[0] - s0), 0);
        check_regs(0);

        // Randomized transfers on both devices
        for (int n = 0; n < 14; n++) begin
            dev   = n % 2;
            cmd   = 8'($urandom);
            nfr   = $urandom_range(1, 3);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            dq    = {};
            for (int k = 0; k <= nfr; k++) dq.push_back($urandom);
            xfer(dev, cmd, nfr, extra);
        end

        // Reset in the middle of a write to reg1
        b = {};
        tmp = 32'h8177;
        for (int i = 15; i >= 3; i--) b.push_back(tmp[i]);
        ss[0] = 1'b0; #100;
        drive_bits(0, b, r);
        rst = 1'b0;
        #20;
        for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) mreg[d][i] = 0;
        check_reset_outs(0);
        check_regs(0);
        check_regs(1);
        rst = 1'b1;
        #200;
        chk("post_rst_ss_still_low_oe", 32'(oe0), 0);
        ss[0] = 1'b1;
        #100;
        dq = {32'h77};
        xfer(0, 8'h81, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
